// File: rtl/sobel_window_sequencer_pkg.sv
// Shared types and widths for the Sobel window sequencer.
package sobel_seq_pkg;
   localparam int PIX_W  = 8;
   localparam int WORD_W = 24;

   typedef enum logic [2:0] {
      IDLE,
      FETCH_A,
      FETCH_B,
      FETCH_C,
      EMIT
   } seq_state_e;
endpackage

// File: rtl/sobel_window_sequencer_if.sv
// Memory read port plus window handshake; master = sequencer, slave = memory/multiplier side.
interface sobel_window_sequencer_if
   import sobel_seq_pkg::*;
#(
   parameter int ADDR_W  = 20,
   parameter int COORD_W = 11
) ();
   logic                mem_req;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_ack;
   logic [PIX_W-1:0]    mem_rdata;
   logic [WORD_W-1:0]   win_a;
   logic [WORD_W-1:0]   win_b;
   logic [WORD_W-1:0]   win_c;
   logic [COORD_W-1:0]  win_x;
   logic [COORD_W-1:0]  win_y;
   logic                win_valid;
   logic                win_ready;
   logic                mult_en;

   modport master (
      output mem_req, mem_addr,
      input  mem_ack, mem_rdata,
      output win_a, win_b, win_c, win_x, win_y, win_valid,
      input  win_ready,
      output mult_en
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_ack, mem_rdata,
      input  win_a, win_b, win_c, win_x, win_y, win_valid,
      output win_ready,
      input  mult_en
   );
endinterface

// File: rtl/sobel_window_sequencer_row_shift.sv
// Three-pixel row register: shifts left one pixel per load, newest pixel at [7:0].
// Clear wins over load; one cycle from load to output.
module sobel_row_shift
   import sobel_seq_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              shift_en_i,
   input  logic [PIX_W-1:0]  pix_i,
   output logic [WORD_W-1:0] row_o
);
   logic [WORD_W-1:0] row_q;
   logic [WORD_W-1:0] row_d;

   always_comb begin
      row_d = row_q;
      if (clr_i) begin
         row_d = '0;
      end else if (shift_en_i) begin
         row_d = {row_q[WORD_W-PIX_W-1:0], pix_i};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         row_q <= '0;
      end else begin
         row_q <= row_d;
      end
   end

   assign row_o = row_q;
endmodule

// File: rtl/sobel_window_sequencer.sv
// Walks a frame column by column, fetching A/B/C pixels and emitting 3x3 windows on a valid/ready port.
// SOBEL_BORDER_ZERO_EN selects zero-padded borders (every pixel a centre); default is interior only.
module sobel_window_sequencer
   import sobel_seq_pkg::*;
#(
   parameter int IMG_W   = 1024,
   parameter int IMG_H   = 1024,
   parameter int ADDR_W  = 20,
   parameter int COORD_W = 11
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic busy,
   output logic done,
   sobel_window_sequencer_if.master bus
);
   typedef logic signed [COORD_W:0] crd_t;

`ifdef SOBEL_BORDER_ZERO_EN
   localparam crd_t FX_FIRST = crd_t'(-1);
   localparam crd_t FX_LAST  = crd_t'(IMG_W);
   localparam crd_t CY_FIRST = crd_t'(0);
   localparam crd_t CY_END   = crd_t'(IMG_H);
   localparam crd_t EMIT_MIN = crd_t'(1);
`else
   localparam crd_t FX_FIRST = crd_t'(0);
   localparam crd_t FX_LAST  = crd_t'(IMG_W - 1);
   localparam crd_t CY_FIRST = crd_t'(1);
   localparam crd_t CY_END   = crd_t'(IMG_H - 1);
   localparam crd_t EMIT_MIN = crd_t'(2);
`endif
   localparam crd_t W_S  = crd_t'(IMG_W);
   localparam crd_t H_S  = crd_t'(IMG_H);
   localparam crd_t ONE  = crd_t'(1);
   localparam crd_t ZERO = crd_t'(0);

   function automatic logic in_frame(input crd_t row, input crd_t col);
      return (row >= ZERO) && (row < H_S) && (col >= ZERO) && (col < W_S);
   endfunction

   function automatic logic [ADDR_W-1:0] pix_addr(input crd_t row, input crd_t col);
      if (!in_frame(row, col)) begin
         return '0;
      end
      return ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
   endfunction

   seq_state_e         state_q;
   crd_t               fx_q;
   crd_t               cy_q;
   logic               mem_req_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic [COORD_W-1:0] win_x_q;
   logic [COORD_W-1:0] win_y_q;
   logic               win_valid_q;
   logic               busy_q;
   logic               done_q;

   logic               fetch_done;
   logic [PIX_W-1:0]   fetch_pix;
   logic               row_wrap;
   logic               frame_end;
   logic               advance;
   crd_t               nxt_fx;
   crd_t               nxt_cy;

   // A fetch with no request is an out-of-frame pad: it completes at once with a zero pixel.
   assign fetch_done = mem_req_q ? bus.mem_ack : 1'b1;
   assign fetch_pix  = mem_req_q ? bus.mem_rdata : '0;

   assign row_wrap  = (fx_q == FX_LAST);
   assign nxt_fx    = row_wrap ? FX_FIRST : fx_q + ONE;
   assign nxt_cy    = row_wrap ? cy_q + ONE : cy_q;
   assign frame_end = row_wrap && (nxt_cy == CY_END);
   assign advance   = ((state_q == FETCH_C) && fetch_done && (fx_q < EMIT_MIN)) ||
                      ((state_q == EMIT) && bus.win_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         fx_q        <= '0;
         cy_q        <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         win_x_q     <= '0;
         win_y_q     <= '0;
         win_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  busy_q     <= 1'b1;
                  fx_q       <= FX_FIRST;
                  cy_q       <= CY_FIRST;
                  mem_req_q  <= in_frame(CY_FIRST - ONE, FX_FIRST);
                  mem_addr_q <= pix_addr(CY_FIRST - ONE, FX_FIRST);
                  state_q    <= FETCH_A;
               end
            end
            FETCH_A: begin
               if (fetch_done) begin
                  mem_req_q  <= in_frame(cy_q, fx_q);
                  mem_addr_q <= pix_addr(cy_q, fx_q);
                  state_q    <= FETCH_B;
               end
            end
            FETCH_B: begin
               if (fetch_done) begin
                  mem_req_q  <= in_frame(cy_q + ONE, fx_q);
                  mem_addr_q <= pix_addr(cy_q + ONE, fx_q);
                  state_q    <= FETCH_C;
               end
            end
            FETCH_C: begin
               if (fetch_done) begin
                  mem_req_q  <= 1'b0;
                  mem_addr_q <= '0;
                  if (fx_q >= EMIT_MIN) begin
                     win_valid_q <= 1'b1;
                     win_x_q     <= COORD_W'(fx_q - ONE);
                     win_y_q     <= cy_q[COORD_W-1:0];
                     state_q     <= EMIT;
                  end
               end
            end
            EMIT: begin
               if (bus.win_ready) begin
                  win_valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase

         // Column/row step shared by the no-emit fetch exit and the window accept.
         if (advance) begin
            fx_q <= nxt_fx;
            cy_q <= nxt_cy;
            if (frame_end) begin
               busy_q     <= 1'b0;
               done_q     <= 1'b1;
               mem_req_q  <= 1'b0;
               mem_addr_q <= '0;
               state_q    <= IDLE;
            end else begin
               mem_req_q  <= in_frame(nxt_cy - ONE, nxt_fx);
               mem_addr_q <= pix_addr(nxt_cy - ONE, nxt_fx);
               state_q    <= FETCH_A;
            end
         end
      end
   end

   sobel_row_shift u_row_a (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (advance && row_wrap),
      .shift_en_i ((state_q == FETCH_A) && fetch_done),
      .pix_i      (fetch_pix),
      .row_o      (bus.win_a)
   );

   sobel_row_shift u_row_b (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (advance && row_wrap),
      .shift_en_i ((state_q == FETCH_B) && fetch_done),
      .pix_i      (fetch_pix),
      .row_o      (bus.win_b)
   );

   sobel_row_shift u_row_c (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (advance && row_wrap),
      .shift_en_i ((state_q == FETCH_C) && fetch_done),
      .pix_i      (fetch_pix),
      .row_o      (bus.win_c)
   );

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.win_x     = win_x_q;
   assign bus.win_y     = win_y_q;
   assign bus.win_valid = win_valid_q;
   assign bus.mult_en   = win_valid_q & bus.win_ready;
   assign busy          = busy_q;
   assign done          = done_q;
endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Scoreboard bench for sobel_window_sequencer on a 5x4 frame whose pixel at address n is n&0xFF.
module tb_sobel_window_sequencer;
   localparam int W = 5;
   localparam int H = 4;
   localparam int AW = 20;
   localparam int CW = 11;
   localparam int NPIX = W * H;
`ifdef SOBEL_BORDER_ZERO_EN
   localparam int NWIN = W * H;
   localparam int XLO = 0, XHI = W - 1, YLO = 0, YHI = H - 1;
   localparam int RST_ADDR = 3;
   localparam logic [93:0] HAND_FIRST = {24'h000000, 24'h000001, 24'h000506, 11'd0, 11'd0};
   localparam logic [93:0] HAND_LAST  = {24'h0D0E00, 24'h121300, 24'h000000, 11'd4, 11'd3};
`else
   localparam int NWIN = (W - 2) * (H - 2);
   localparam int XLO = 1, XHI = W - 2, YLO = 1, YHI = H - 2;
   localparam int RST_ADDR = 9;
   localparam logic [93:0] HAND_FIRST = {24'h000102, 24'h050607, 24'h0A0B0C, 11'd1, 11'd1};
   localparam logic [93:0] HAND_LAST  = {24'h070809, 24'h0C0D0E, 24'h111213, 11'd3, 11'd2};
`endif

   typedef struct packed {
      logic [23:0] a;
      logic [23:0] b;
      logic [23:0] c;
      logic [10:0] x;
      logic [10:0] y;
   } win_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic busy, done;

   int nvec = 0, nerr = 0;
   int acc_cnt = 0, done_cnt = 0, stall_cyc = 0, stall_base = 0, wait_cnt = 0;
   int ack_delay = 0;
   logic stall_en = 1'b0;
   win_t exp_q[$];
   win_t got_q[$];
   win_t prev_win;
   logic prev_stall = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
   logic [AW-1:0] prev_addr = '0;

   sobel_window_sequencer_if #(.ADDR_W(AW), .COORD_W(CW)) bus ();

   sobel_window_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .COORD_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pix(input int r, input int c);
      if (r < 0 || r >= H || c < 0 || c >= W) return 8'h00;
      return 8'((r * W + c) & 255);
   endfunction

   task automatic push_frame();
      win_t e;
      for (int y = YLO; y <= YHI; y++) begin
         for (int x = XLO; x <= XHI; x++) begin
            e.a = {pix(y - 1, x - 1), pix(y - 1, x), pix(y - 1, x + 1)};
            e.b = {pix(y, x - 1), pix(y, x), pix(y, x + 1)};
            e.c = {pix(y + 1, x - 1), pix(y + 1, x), pix(y + 1, x + 1)};
            e.x = 11'(x);
            e.y = 11'(y);
            exp_q.push_back(e);
         end
      end
   endtask

   // Memory: acknowledges each request after ack_delay waiting cycles.
   assign bus.mem_ack   = bus.mem_req && (wait_cnt >= ack_delay);
   assign bus.mem_rdata = bus.mem_addr[7:0];

   always @(posedge clk) begin
      if (reset || !bus.mem_req || bus.mem_ack) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end

   initial begin
      bus.win_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.win_ready = !(stall_en && (acc_cnt - stall_base == 1) && (stall_cyc < 5));
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         prev_stall <= 1'b0;
         prev_req   <= 1'b0;
      end else begin
         chk("mult_en", bus.mult_en, bus.win_valid & bus.win_ready);
         if (bus.win_valid) chk("req_in_emit", bus.mem_req, 1'b0);
         if (prev_stall) begin
            chk("stall_valid", bus.win_valid, 1'b1);
            chk("stall_hold", win_t'({bus.win_a, bus.win_b, bus.win_c, bus.win_x, bus.win_y}), prev_win);
         end
         if (prev_req && !prev_ack) begin
            chk("req_hold", bus.mem_req, 1'b1);
            chk("addr_hold", bus.mem_addr, prev_addr);
         end
         if (bus.mem_req) chk("addr_range", bus.mem_addr < AW'(NPIX), 1'b1);
         if (bus.mult_en) begin
            chk("exp_avail", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               chk("win", win_t'({bus.win_a, bus.win_b, bus.win_c, bus.win_x, bus.win_y}), exp_q[0]);
               void'(exp_q.pop_front());
            end
            got_q.push_back(win_t'({bus.win_a, bus.win_b, bus.win_c, bus.win_x, bus.win_y}));
            acc_cnt <= acc_cnt + 1;
         end
         if (!stall_en) stall_cyc <= 0;
         else if ((acc_cnt - stall_base == 1) && bus.win_valid && !bus.win_ready) stall_cyc <= stall_cyc + 1;
         if (done) begin
            done_cnt <= done_cnt + 1;
            chk("busy_at_done", busy, 1'b0);
         end
         prev_stall <= bus.win_valid && !bus.win_ready;
         prev_win   <= win_t'({bus.win_a, bus.win_b, bus.win_c, bus.win_x, bus.win_y});
         prev_req   <= bus.mem_req;
         prev_ack   <= bus.mem_ack;
         prev_addr  <= bus.mem_addr;
      end
   end

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_mem_req"}, bus.mem_req, 1'b0);
      chk({tag, "_mem_addr"}, bus.mem_addr, '0);
      chk({tag, "_win_valid"}, bus.win_valid, 1'b0);
      chk({tag, "_win_abc"}, {bus.win_a, bus.win_b, bus.win_c}, '0);
      chk({tag, "_win_xy"}, {bus.win_x, bus.win_y}, '0);
      chk({tag, "_mult_en"}, bus.mult_en, 1'b0);
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic check_hand(input string tag);
      chk({tag, "_first"}, got_q[0], HAND_FIRST);
      chk({tag, "_last"}, got_q[$], HAND_LAST);
   endtask

   task automatic run_frame(input string tag, input int extra_start);
      int d0, a0;
      logic seen;
      got_q.delete();
      push_frame();
      d0 = done_cnt;
      a0 = acc_cnt;
      pulse_start();
      @(negedge clk);
      chk({tag, "_busy_rise"}, busy, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (i == extra_start) start = 1'b1;
         else start = 1'b0;
         if (done_cnt != d0) seen = 1'b1;
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, seen, 1'b1);
      repeat (5) @(negedge clk);
      chk({tag, "_done_pulses"}, done_cnt - d0, 1);
      chk({tag, "_win_count"}, acc_cnt - a0, NWIN);
      chk({tag, "_exp_left"}, exp_q.size(), 0);
      chk({tag, "_busy_after"}, busy, 1'b0);
      exp_q.delete();
   endtask

   initial begin
      int d0, a0;
      logic seen;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      @(posedge clk);
      #1 reset = 1'b0;

      run_frame("basic", -1);
      check_hand("basic");

      stall_base = acc_cnt;
      stall_en = 1'b1;
      run_frame("bp", -1);
      chk("bp_stall_cycles", stall_cyc, 5);
      stall_en = 1'b0;
      check_hand("bp");

      ack_delay = 3;
      run_frame("lat", -1);
      check_hand("lat");
      ack_delay = 0;

      // Abort during the third window's centre-row fetch, with start raised alongside reset.
      got_q.delete();
      push_frame();
      d0 = done_cnt;
      a0 = acc_cnt;
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 500 && !seen; i++) begin
         @(posedge clk);
         if (acc_cnt == a0 + 2) seen = 1'b1;
      end
      chk("rst_reach_w2", seen, 1'b1);
      #1;
      @(posedge clk);
      #1;
      chk("rst_fetchb_req", bus.mem_req, 1'b1);
      chk("rst_fetchb_addr", bus.mem_addr, AW'(RST_ADDR));
      reset = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      check_idle("rst_mid");
      reset = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("start_with_reset", busy, 1'b0);
      repeat (10) @(negedge clk);
      chk("rst_no_done", done_cnt - d0, 0);
      chk("rst_win_count", acc_cnt - a0, 2);
      exp_q.delete();
      run_frame("after_rst", -1);
      check_hand("after_rst");

      run_frame("start_busy", 12);
      check_hand("start_busy");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
